pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Parametrised pipeline control unit for the 5-stage MIPS core. It tracks in-flight destination registers across a configurable number of post-decode stages and generates operand-forwarding selects, load-use stalls and branch flushes. It also counts stall and flush cycles. It sits beside the ID stage and drives the IF/ID and ID/EX register enables and the EX operand muxes.

Parameters:
REG_ADDR_WIDTH, 5, register index width
NUM_STAGES, 3, tracked post-decode stages (index 0 = EX, 1 = MEM, 2 = WB, ...)
LOAD_LAT, 1, first stage index whose output carries load data; valid range 0..NUM_STAGES-1
CNT_WIDTH, 32, width of the performance counters
SEL_WIDTH, $clog2(NUM_STAGES+1), forwarding select width (derived)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_hold  in  1  external freeze (memory wait); no tracking state advances
i_id_valid  in  1  ID holds a real instruction
i_id_rs  in  REG_ADDR_WIDTH  source register 0
i_id_rt  in  REG_ADDR_WIDTH  source register 1
i_id_rs_used  in  1  rs is read
i_id_rt_used  in  1  rt is read
i_id_rd  in  REG_ADDR_WIDTH  destination register
i_id_wr_en  in  1  instruction writes rd
i_id_is_load  in  1  instruction is a load
i_ex_branch_taken  in  1  branch in EX resolved taken
o_stall  out  1  hold PC and IF/ID; insert bubble into EX
o_flush  out  1  squash IF/ID and the ID instruction
o_issue  out  1  ID instruction enters EX this cycle
o_fwd_rs_sel  out  SEL_WIDTH  0 = register file; k+1 = output of stage k
o_fwd_rt_sel  out  SEL_WIDTH  same encoding as o_fwd_rs_sel
o_stall_cnt  out  CNT_WIDTH  stall cycles since reset, saturating
o_flush_cnt  out  CNT_WIDTH  flush cycles since reset, saturating

Behaviour:
- State: NUM_STAGES-entry shift register. Each entry holds {valid, rd, wr_en, is_load}. There are also two counters.
- Reset (i_rst sampled high at posedge): all entries invalid, both counters 0. With no valid entries, all combinational outputs fall to o_stall=0, o_flush=0 and fwd sels = 0; o_issue follows i_id_valid.
- Match of source s against entry k: valid & wr_en & rd==s & s!=0 & the corresponding *_used input is 1.
- Forward select: the lowest matching k (youngest) wins; the select is k+1. No match gives 0. Register 0 never forwards.
- Load-use hazard: the youngest match is a load with k < LOAD_LAT. This raises o_stall = i_id_valid & hazard & ~i_ex_branch_taken & ~i_hold.
- o_flush = i_ex_branch_taken & ~i_hold. Flush has priority over stall: a hazard in the same cycle gives o_stall=0.
- o_issue = i_id_valid & ~o_stall & ~o_flush & ~i_hold.
- Advance every posedge when ~i_hold:
  - entry[k] <= entry[k-1] for k ≥ 1.
  - entry[0] <= ID fields with valid=o_issue; a bubble (valid=0) is inserted on stall or flush.
- With i_hold=1: entries and counters are frozen; o_stall, o_flush and o_issue are 0. Forward selects are still computed from the frozen entries.
- A stalled instruction re-evaluates each cycle. With LOAD_LAT=1, a load in EX immediately ahead gives exactly 1 stall cycle. With LOAD_LAT=L, the stall lasts at most L cycles.
- Counters:
  - o_stall_cnt += 1 on each cycle with o_stall=1.
  - o_flush_cnt += 1 on each cycle with o_flush=1.
  - Both saturate at all-ones and never wrap.
- All outputs except the counters are combinational from state and inputs. The counters are registered.
- Reset asserted mid-stall clears everything the next cycle; the pending instruction is treated as new.

Decomposition:
- Shared package core_pkg holds REG_ADDR_WIDTH, the stage index constants (STG_EX=0, STG_MEM=1, STG_WB=2) and the forwarding select encoding constants (FWD_RF=0).
- One sub-module, pipe_ctrl_fwd_match: combinational priority match of one source register against all entries. It returns {sel, hazard} and is instantiated twice (rs, rt).

Test Plan:
1. Reset then idle: i_rst=1 for 2 cycles, i_id_valid=0 -> all outputs 0, counters 0.
2. ALU back-to-back: issue add rd=3, then ID rs=3 rs_used=1 -> o_fwd_rs_sel=1, o_stall=0. The next cycle with ID rs=3 gives sel=2.
3. Load-use: issue lw rd=5, then ID rt=5 rt_used=1 (LOAD_LAT=1) -> o_stall=1 for exactly 1 cycle, then o_fwd_rt_sel=2 and o_issue=1; o_stall_cnt=1.
4. Register 0 and priority: entries EX rd=0 wr_en and MEM rd=7, ID rs=0 and rt=7 -> rs_sel=0, rt_sel=2. With both EX and MEM holding rd=7 -> rt_sel=1.
5. Flush over stall: load-use hazard and i_ex_branch_taken=1 in the same cycle -> o_flush=1, o_stall=0, o_issue=0, entry[0] is a bubble; o_flush_cnt +1, o_stall_cnt unchanged.
6. Hold and saturation:
   - i_hold=1 for 4 cycles during a hazard -> entries frozen, counters unchanged; after release, o_stall=1 for 1 cycle.
   - With CNT_WIDTH=4 and 20 forced stalls -> o_stall_cnt=15.

Source files
------------

// File: rtl/core_pkg.sv
// Shared constants for the 5-stage MIPS core: register index width,
// post-decode stage indices and the forwarding select encoding.
package core_pkg;

   localparam int REG_ADDR_WIDTH = 5;

   localparam int STG_EX  = 0;
   localparam int STG_MEM = 1;
   localparam int STG_WB  = 2;

   localparam int FWD_RF  = 0;

endpackage

// File: rtl/pipe_ctrl_fwd_match.sv
// Priority match of one ID source register against the in-flight entries.
// Returns the forwarding select of the youngest writer and whether it is an early load.
module pipe_ctrl_fwd_match #(
   parameter int REG_ADDR_WIDTH = core_pkg::REG_ADDR_WIDTH,
   parameter int NUM_STAGES     = 3,
   parameter int LOAD_LAT       = 1,
   parameter int SEL_WIDTH      = $clog2(NUM_STAGES + 1)
) (
   input  logic [REG_ADDR_WIDTH-1:0]                  i_src,
   input  logic                                       i_used,
   input  logic [NUM_STAGES-1:0]                      i_valid,
   input  logic [NUM_STAGES-1:0]                      i_wr_en,
   input  logic [NUM_STAGES-1:0]                      i_is_load,
   input  logic [NUM_STAGES-1:0][REG_ADDR_WIDTH-1:0]  i_rd,
   output logic [SEL_WIDTH-1:0]                       o_sel,
   output logic                                       o_hazard
);

   import core_pkg::*;

   logic found;

   // Scan from EX outward so the youngest writer claims the select.
   always_comb begin
      o_sel    = SEL_WIDTH'(FWD_RF);
      o_hazard = 1'b0;
      found    = 1'b0;
      for (int k = 0; k < NUM_STAGES; k++) begin
         if (!found && i_used && (i_src != '0) && i_valid[k] && i_wr_en[k] && (i_rd[k] == i_src)) begin
            found    = 1'b1;
            o_sel    = SEL_WIDTH'(k + 1);
            o_hazard = i_is_load[k] && (k < LOAD_LAT);
         end
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control beside ID: tracks in-flight destinations, drives forwarding
// selects, load-use stalls, branch flushes and saturating stall/flush counters.
module pipe_ctrl #(
   parameter int REG_ADDR_WIDTH = core_pkg::REG_ADDR_WIDTH,
   parameter int NUM_STAGES     = 3,
   parameter int LOAD_LAT       = 1,
   parameter int CNT_WIDTH      = 32,
   parameter int SEL_WIDTH      = $clog2(NUM_STAGES + 1)
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_hold,
   input  logic                      i_id_valid,
   input  logic [REG_ADDR_WIDTH-1:0] i_id_rs,
   input  logic [REG_ADDR_WIDTH-1:0] i_id_rt,
   input  logic                      i_id_rs_used,
   input  logic                      i_id_rt_used,
   input  logic [REG_ADDR_WIDTH-1:0] i_id_rd,
   input  logic                      i_id_wr_en,
   input  logic                      i_id_is_load,
   input  logic                      i_ex_branch_taken,
   output logic                      o_stall,
   output logic                      o_flush,
   output logic                      o_issue,
   output logic [SEL_WIDTH-1:0]      o_fwd_rs_sel,
   output logic [SEL_WIDTH-1:0]      o_fwd_rt_sel,
   output logic [CNT_WIDTH-1:0]      o_stall_cnt,
   output logic [CNT_WIDTH-1:0]      o_flush_cnt
);

   import core_pkg::*;

   logic [NUM_STAGES-1:0]                      valid_q, valid_d;
   logic [NUM_STAGES-1:0]                      wr_en_q, wr_en_d;
   logic [NUM_STAGES-1:0]                      is_load_q, is_load_d;
   logic [NUM_STAGES-1:0][REG_ADDR_WIDTH-1:0]  rd_q, rd_d;
   logic [CNT_WIDTH-1:0]                       stall_cnt_q, stall_cnt_d;
   logic [CNT_WIDTH-1:0]                       flush_cnt_q, flush_cnt_d;
   logic                                       rs_hazard, rt_hazard;

   pipe_ctrl_fwd_match #(
      .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
      .NUM_STAGES     (NUM_STAGES),
      .LOAD_LAT       (LOAD_LAT),
      .SEL_WIDTH      (SEL_WIDTH)
   ) u_match_rs (
      .i_src     (i_id_rs),
      .i_used    (i_id_rs_used),
      .i_valid   (valid_q),
      .i_wr_en   (wr_en_q),
      .i_is_load (is_load_q),
      .i_rd      (rd_q),
      .o_sel     (o_fwd_rs_sel),
      .o_hazard  (rs_hazard)
   );

   pipe_ctrl_fwd_match #(
      .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
      .NUM_STAGES     (NUM_STAGES),
      .LOAD_LAT       (LOAD_LAT),
      .SEL_WIDTH      (SEL_WIDTH)
   ) u_match_rt (
      .i_src     (i_id_rt),
      .i_used    (i_id_rt_used),
      .i_valid   (valid_q),
      .i_wr_en   (wr_en_q),
      .i_is_load (is_load_q),
      .i_rd      (rd_q),
      .o_sel     (o_fwd_rt_sel),
      .o_hazard  (rt_hazard)
   );

   // A taken branch squashes ID, so it overrides any load-use stall.
   assign o_flush     = i_ex_branch_taken & ~i_hold;
   assign o_stall     = i_id_valid & (rs_hazard | rt_hazard) & ~i_ex_branch_taken & ~i_hold;
   assign o_issue     = i_id_valid & ~o_stall & ~o_flush & ~i_hold;
   assign o_stall_cnt = stall_cnt_q;
   assign o_flush_cnt = flush_cnt_q;

   always_comb begin
      valid_d     = valid_q;
      wr_en_d     = wr_en_q;
      is_load_d   = is_load_q;
      rd_d        = rd_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!i_hold) begin
         for (int k = 1; k < NUM_STAGES; k++) begin
            valid_d[k]   = valid_q[k-1];
            wr_en_d[k]   = wr_en_q[k-1];
            is_load_d[k] = is_load_q[k-1];
            rd_d[k]      = rd_q[k-1];
         end
         valid_d[STG_EX]   = o_issue;
         wr_en_d[STG_EX]   = i_id_wr_en;
         is_load_d[STG_EX] = i_id_is_load;
         rd_d[STG_EX]      = i_id_rd;
      end
      if (o_stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
      end
      if (o_flush && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         valid_q     <= '0;
         wr_en_q     <= '0;
         is_load_q   <= '0;
         rd_q        <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         valid_q     <= valid_d;
         wr_en_q     <= wr_en_d;
         is_load_q   <= is_load_d;
         rd_q        <= rd_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: hand-derived expectations are queued as each
// ID cycle is driven and compared against the DUT just before the next clock edge.
module tb_pipe_ctrl;

   logic       clk = 1'b0;
   logic       rst, hold, id_valid, rs_used, rt_used, wr_en, is_load, br;
   logic [4:0] rs, rt, rd;

   logic        stall, flush, issue;
   logic [1:0]  rs_sel, rt_sel;
   logic [31:0] stall_cnt, flush_cnt;

   logic        s_stall, s_flush, s_issue;
   logic [1:0]  s_rs_sel, s_rt_sel;
   logic [3:0]  s_stall_cnt, s_flush_cnt;

   typedef struct {
      string      tag;
      logic       stall;
      logic       flush;
      logic       issue;
      logic [1:0] rs_sel;
      logic [1:0] rt_sel;
      int         scnt;
      int         fcnt;
      int         sat;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   exp_scnt = 0;
   int   exp_fcnt = 0;

   always #5 clk = ~clk;

   pipe_ctrl dut (
      .i_clk(clk), .i_rst(rst), .i_hold(hold), .i_id_valid(id_valid),
      .i_id_rs(rs), .i_id_rt(rt), .i_id_rs_used(rs_used), .i_id_rt_used(rt_used),
      .i_id_rd(rd), .i_id_wr_en(wr_en), .i_id_is_load(is_load), .i_ex_branch_taken(br),
      .o_stall(stall), .o_flush(flush), .o_issue(issue),
      .o_fwd_rs_sel(rs_sel), .o_fwd_rt_sel(rt_sel),
      .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
   );

   // Narrow-counter copy sharing the same stimulus, used for saturation.
   pipe_ctrl #(.CNT_WIDTH(4)) dut_sat (
      .i_clk(clk), .i_rst(rst), .i_hold(hold), .i_id_valid(id_valid),
      .i_id_rs(rs), .i_id_rt(rt), .i_id_rs_used(rs_used), .i_id_rt_used(rt_used),
      .i_id_rd(rd), .i_id_wr_en(wr_en), .i_id_is_load(is_load), .i_ex_branch_taken(br),
      .o_stall(s_stall), .o_flush(s_flush), .o_issue(s_issue),
      .o_fwd_rs_sel(s_rs_sel), .o_fwd_rt_sel(s_rt_sel),
      .o_stall_cnt(s_stall_cnt), .o_flush_cnt(s_flush_cnt)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic resetDut();
      @(negedge clk);
      rst = 1'b1; hold = 1'b0; id_valid = 1'b0; br = 1'b0;
      rs = '0; rt = '0; rd = '0; rs_used = 1'b0; rt_used = 1'b0; wr_en = 1'b0; is_load = 1'b0;
      repeat (2) @(posedge clk);
      exp_scnt = 0;
      exp_fcnt = 0;
      sb.delete();
   endtask

   task automatic applyStimulus(
      input string tag,
      input logic v, input logic [4:0] s0, input logic u0, input logic [4:0] s1, input logic u1,
      input logic [4:0] d, input logic w, input logic ld, input logic b, input logic h,
      input logic e_stall, input logic e_flush, input logic e_issue,
      input logic [1:0] e_rs, input logic [1:0] e_rt);
      exp_t e, got;
      @(negedge clk);
      rst = 1'b0; id_valid = v; rs = s0; rs_used = u0; rt = s1; rt_used = u1;
      rd = d; wr_en = w; is_load = ld; br = b; hold = h;
      e.tag = tag; e.stall = e_stall; e.flush = e_flush; e.issue = e_issue;
      e.rs_sel = e_rs; e.rt_sel = e_rt; e.scnt = exp_scnt; e.fcnt = exp_fcnt;
      e.sat = (exp_scnt > 15) ? 15 : exp_scnt;
      sb.push_back(e);
      #2;
      got = sb.pop_front();
      checkOutput({got.tag, ".stall"},     {31'b0, stall},  {31'b0, got.stall});
      checkOutput({got.tag, ".flush"},     {31'b0, flush},  {31'b0, got.flush});
      checkOutput({got.tag, ".issue"},     {31'b0, issue},  {31'b0, got.issue});
      checkOutput({got.tag, ".rs_sel"},    {30'b0, rs_sel}, {30'b0, got.rs_sel});
      checkOutput({got.tag, ".rt_sel"},    {30'b0, rt_sel}, {30'b0, got.rt_sel});
      checkOutput({got.tag, ".stall_cnt"}, stall_cnt,       got.scnt);
      checkOutput({got.tag, ".flush_cnt"}, flush_cnt,       got.fcnt);
      checkOutput({got.tag, ".sat_cnt"},   {28'b0, s_stall_cnt}, got.sat);
      if (got.stall) exp_scnt++;
      if (got.flush) exp_fcnt++;
   endtask

   initial begin
      $display("[TB] pipe_ctrl scoreboard bench start");
      resetDut();
      applyStimulus("idle",         0, 0,0, 0,0, 0,0,0, 0,0,  0,0,0, 0,0);
      applyStimulus("add_issue",    1, 1,0, 2,0, 3,1,0, 0,0,  0,0,1, 0,0);
      applyStimulus("alu_fwd_ex",   1, 3,1, 0,0, 4,1,0, 0,0,  0,0,1, 1,0);
      applyStimulus("alu_fwd_mem",  1, 3,1, 0,0, 0,0,0, 0,0,  0,0,1, 2,0);
      applyStimulus("alu_fwd_wb",   0, 3,1, 0,0, 0,0,0, 0,0,  0,0,0, 3,0);
      applyStimulus("lw_issue",     1, 0,0, 0,0, 5,1,1, 0,0,  0,0,1, 0,0);
      applyStimulus("load_use",     1, 0,0, 5,1, 6,1,0, 0,0,  1,0,0, 0,1);
      applyStimulus("load_use_fwd", 1, 0,0, 5,1, 6,1,0, 0,0,  0,0,1, 0,2);
      applyStimulus("rd7_issue",    1, 0,0, 0,0, 7,1,0, 0,0,  0,0,1, 0,0);
      applyStimulus("rd0_issue",    1, 0,0, 0,0, 0,1,0, 0,0,  0,0,1, 0,0);
      applyStimulus("reg0_prio",    1, 0,1, 7,1, 7,1,0, 0,0,  0,0,1, 0,2);
      applyStimulus("rd7_again",    1, 0,0, 7,1, 7,1,0, 0,0,  0,0,1, 0,1);
      applyStimulus("youngest",     0, 0,0, 7,1, 0,0,0, 0,0,  0,0,0, 0,1);
      applyStimulus("lw5_again",    1, 0,0, 0,0, 5,1,1, 0,0,  0,0,1, 0,0);
      applyStimulus("flush_prio",   1, 0,0, 5,1, 8,1,0, 1,0,  0,1,0, 0,1);
      applyStimulus("post_flush",   0, 8,1, 5,1, 0,0,0, 0,0,  0,0,0, 0,2);
      applyStimulus("lw9_issue",    1, 0,0, 0,0, 9,1,1, 0,0,  0,0,1, 0,0);
      applyStimulus("hold0",        1, 9,1, 0,0,10,1,0, 0,1,  0,0,0, 1,0);
      applyStimulus("hold1",        1, 9,1, 0,0,10,1,0, 0,1,  0,0,0, 1,0);
      applyStimulus("hold2_br",     1, 9,1, 0,0,10,1,0, 1,1,  0,0,0, 1,0);
      applyStimulus("hold3",        1, 9,1, 0,0,10,1,0, 0,1,  0,0,0, 1,0);
      applyStimulus("hold_release", 1, 9,1, 0,0,10,1,0, 0,0,  1,0,0, 1,0);
      applyStimulus("hold_fwd",     1, 9,1, 0,0,10,1,0, 0,0,  0,0,1, 2,0);
      applyStimulus("lw11_issue",   1, 0,0, 0,0,11,1,1, 0,0,  0,0,1, 0,0);
      applyStimulus("mid_stall",    1,11,1, 0,0,12,1,0, 0,0,  1,0,0, 1,0);
      resetDut();
      applyStimulus("post_reset",   1,11,1, 0,0,12,1,0, 0,0,  0,0,1, 0,0);
      applyStimulus("sat_first",    1, 0,0, 5,1, 5,1,1, 0,0,  0,0,1, 0,0);
      for (int i = 0; i < 20; i++) begin
         applyStimulus("sat_stall", 1, 0,0, 5,1, 5,1,1, 0,0,  1,0,0, 0,1);
         applyStimulus("sat_issue", 1, 0,0, 5,1, 5,1,1, 0,0,  0,0,1, 0,2);
      end
      applyStimulus("sat_done",     0, 0,0, 0,0, 0,0,0, 0,0,  0,0,0, 0,0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
